// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer: load-use stalls, taken-branch flushes and multi-cycle mul holds.
// Optional stall-cycle counter is built only when STALL_COUNTER_EN is defined.
module hazard_stall_controller #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_IsMul,
    input  logic        EX_R_Enable,
    input  logic [4:0]  EX_DstReg,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Write,
    output logic        IDEX_Bubble,
    output logic        EXMEM_Bubble,
    output logic        MulBusy,
    output logic [31:0] StallCount,
    output logic        dbg_state
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // A single-cycle mul never waits, so the reload value only matters when MUL_LATENCY > 1.
    localparam bit         MUL_MULTI = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = MUL_MULTI ? CNT_W'(MUL_LATENCY - 2) : '0;

    state_t           state, state_next;
    logic [CNT_W-1:0] mul_cnt, mul_cnt_next;
    logic             load_use;

    assign dbg_state = state;

    assign load_use = EX_R_Enable && (EX_DstReg != 5'd0) &&
                      ((EX_DstReg == ID_Rs) || (ID_UsesRt && (EX_DstReg == ID_Rt)));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            state   <= state_next;
            mul_cnt <= mul_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        mul_cnt_next = mul_cnt;
        case (state)
            RUN: begin
                if (BranchTaken) begin
                    state_next = RUN;
                end else if (load_use) begin
                    state_next = RUN;
                end else if (ID_IsMul && MUL_MULTI) begin
                    state_next   = MUL_WAIT;
                    mul_cnt_next = MUL_LOAD;
                end
            end
            MUL_WAIT: begin
                // EX is occupied by the mul, so branch and load-use indications are not genuine here.
                if (mul_cnt != '0) begin
                    mul_cnt_next = mul_cnt - CNT_W'(1);
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next   = RUN;
                mul_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        MulBusy      = 1'b0;
        if (Rst) begin
            case (state)
                RUN: begin
                    if (BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    PCWrite      = 1'b0;
                    IFID_Write   = 1'b0;
                    IDEX_Write   = 1'b0;
                    EXMEM_Bubble = 1'b1;
                    MulBusy      = 1'b1;
                end
                default: begin
                    PCWrite = 1'b1;
                end
            endcase
        end
    end

`ifdef STALL_COUNTER_EN
    // Counts every front-end stall cycle outside reset, saturating instead of wrapping.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            StallCount <= 32'h0;
        end else if (!PCWrite && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`else
    assign StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed bench for hazard_stall_controller against a cycle-level reference model.
module tb_hazard_stall_controller;

    localparam int LAT = 3;
    localparam int W   = 39;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  ID_Rs, ID_Rt, EX_DstReg;
    logic        ID_UsesRt, ID_IsMul, EX_R_Enable, BranchTaken;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulBusy;
    logic [31:0] StallCount;
    logic        dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: number of front-end stall cycles still owed to an in-flight mul, and total stalls seen.
    int          m_mul_left = 0;
    longint      m_stalls   = 0;

    hazard_stall_controller #(.MUL_LATENCY(LAT), .CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_IsMul(ID_IsMul),
        .EX_R_Enable(EX_R_Enable), .EX_DstReg(EX_DstReg), .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
        .MulBusy(MulBusy), .StallCount(StallCount), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    // One cycle: drive at the falling edge, sample 1 ns later, record model expectation, advance model.
    task automatic drive(input logic rst, input logic br, input logic ld, input logic mul,
                         input logic uses_rt, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst);
        logic        lu;
        logic [6:0]  e;
        logic [31:0] sc;
        @(negedge Clk);
        Rst = rst; BranchTaken = br; EX_R_Enable = ld; ID_IsMul = mul;
        ID_UsesRt = uses_rt; ID_Rs = rs; ID_Rt = rt; EX_DstReg = dst;
        #1;
        lu = ld && (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
        // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulBusy}
        e = 7'b1101000;
        if (rst) begin
            if (m_mul_left > 0) e = 7'b0000011;
            else if (br)        e = 7'b1111100;
            else if (lu)        e = 7'b0001100;
        end
`ifdef STALL_COUNTER_EN
        sc = (m_stalls > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
`else
        sc = 32'h0;
`endif
        exp_q.push_back({e, sc});
        obs_q.push_back({PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
                         EXMEM_Bubble, MulBusy, StallCount});
        if (!rst) begin
            m_mul_left = 0;
            m_stalls   = 0;
        end else if (m_mul_left > 0) begin
            m_mul_left = m_mul_left - 1;
            m_stalls   = m_stalls + 1;
        end else if (br) begin
            m_mul_left = 0;
        end else if (lu) begin
            m_stalls = m_stalls + 1;
        end else if (mul && (LAT > 1)) begin
            m_mul_left = LAT - 1;
        end
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    endtask

    task automatic test_reset();
        logic [W-1:0] e, o;
        Rst = 1'b0; BranchTaken = 1'b1; ID_IsMul = 1'b1; EX_R_Enable = 1'b0;
        ID_UsesRt = 1'b0; ID_Rs = '0; ID_Rt = '0; EX_DstReg = '0;
        repeat (2) @(posedge Clk);
        m_mul_left = 0; m_stalls = 0;
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset: got %h required %h", o, e); end
        end
    endtask

    task automatic test_load_use();
        logic [W-1:0] e, o;
        int stalls;
        stalls = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 5'd8);
        idle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd8, 5'd8);
        idle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd8, 5'd8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[W-1] === 1'b0) stalls++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL load_use: got %h required %h", o, e); end
        end
        n_checks++;
        if (stalls !== 2) begin n_fail++; $display("FAIL load_use_count: got %0d required 2", stalls); end
    endtask

    task automatic test_mul(input string name, input int reset_at);
        logic [W-1:0] e, o;
        int stalls, busy;
        stalls = 0; busy = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
        for (int i = 1; i <= LAT + 1; i++) begin
            if (i == reset_at) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
            else               idle();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[W-1] === 1'b0) stalls++;
            if (o[32] === 1'b1) busy++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", name, o, e); end
        end
        n_checks++;
        if (busy !== ((reset_at > 0) ? reset_at - 1 : LAT - 1)) begin
            n_fail++; $display("FAIL %s_busy: got %0d cycles required %0d", name, busy,
                               (reset_at > 0) ? reset_at - 1 : LAT - 1);
        end
        if (reset_at == 0) begin
            n_checks++;
            if (stalls !== LAT - 1) begin
                n_fail++; $display("FAIL %s_stalls: got %0d required %0d", name, stalls, LAT - 1);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] e, o;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8);
        idle();
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o[38:32] !== 7'b1111100) begin
            n_fail++; $display("FAIL simultaneous: got %b required 1111100", o[38:32]);
        end
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL simultaneous_after: got %h required %h", o, e); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, o;
        int stalls;
        stalls = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < LAT - 1; i++) idle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < LAT + 1; i++) idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[W-1] === 1'b0) stalls++;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL back_to_back: got %h required %h", o, e); end
        end
        n_checks++;
        if (stalls !== 2 * (LAT - 1)) begin
            n_fail++; $display("FAIL back_to_back_stalls: got %0d required %0d", stalls, 2 * (LAT - 1));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e, o;
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random[%0d]: got %h required %h", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul("mul", 0);
        test_simultaneous();
        test_mul("reset_mid_mul", 2);
        test_mul("mul_after_reset", 0);
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencer for the 5-stage MIPS datapath that the decode-stage Controller drives.
- Detects load-use hazards and taken branches/jumps, and holds the EX stage for the multi-cycle mul (SPECIAL2, opcode 6'b011100).
- Drives the write enables, bubble inserts and flushes of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Sits beside the Controller; all pipeline-register control comes from this block.

Parameters:
- MUL_LATENCY, 3: cycles the mul occupies EX. Legal range 1..15.
- CNT_W, 4: width of the internal mul cycle counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  synchronous reset, active-low.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- ID_UsesRt  input  1  instruction in ID reads rt as a source.
- ID_IsMul  input  1  instruction in ID is mul.
- EX_R_Enable  input  1  instruction in EX is a load (lw/lh/lb).
- EX_DstReg  input  5  destination register of the instruction in EX.
- BranchTaken  input  1  branch/jump/jr resolved taken in EX this cycle.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID register enable.
- IFID_Flush  output  1  clear IF/ID to nop.
- IDEX_Write  output  1  ID/EX register enable.
- IDEX_Bubble  output  1  load nop into ID/EX.
- EXMEM_Bubble  output  1  load nop into EX/MEM.
- MulBusy  output  1  mul is holding EX.
- StallCount  output  32  stall cycle counter (see Optional Feature).

Behaviour:
- States: RUN, MUL_WAIT. Register MulCnt is CNT_W bits wide.
- Outputs are combinational from the state, MulCnt and the inputs. Only the state, MulCnt and StallCount are registered.
- Default outputs: PCWrite=1, IFID_Write=1, IDEX_Write=1; IFID_Flush, IDEX_Bubble, EXMEM_Bubble and MulBusy all 0.
- Reset: when Rst=0 at a rising edge, next state is RUN, MulCnt=0 and StallCount=0.
  - While Rst=0, all outputs take their default values.
  - Reset in MUL_WAIT abandons the mul immediately.
- LoadUse = EX_R_Enable & (EX_DstReg!=0) & ((EX_DstReg==ID_Rs) | (ID_UsesRt & EX_DstReg==ID_Rt)).
- RUN priority, highest first:
  1. BranchTaken=1:
     - Drive IFID_Flush=1 and IDEX_Bubble=1; PCWrite=1 and IFID_Write=1.
     - LoadUse and ID_IsMul are ignored; the instruction in ID is squashed.
     - Next state RUN.
  2. LoadUse=1:
     - Drive PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
     - Next state RUN. Exactly one stall cycle, because the load moves to MEM and LoadUse deasserts.
     - A mul in ID under load-use is not launched this cycle.
  3. ID_IsMul=1 and MUL_LATENCY>1:
     - Outputs stay at defaults, so the mul enters EX.
     - Next state MUL_WAIT, MulCnt=MUL_LATENCY-2.
  4. Otherwise: defaults, stay in RUN.
- MUL_WAIT:
  - Drive PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1, MulBusy=1.
  - If MulCnt!=0, decrement MulCnt and stay.
  - If MulCnt==0, next state RUN; the following cycle releases with defaults and the mul result passes to MEM.
  - BranchTaken and LoadUse are ignored in MUL_WAIT; EX holds the mul, so neither can be genuine.
- Total: the mul spends MUL_LATENCY cycles in EX and the front end stalls MUL_LATENCY-1 cycles.
- MUL_LATENCY=1: MUL_WAIT is never entered.
- A back-to-back mul (mul in ID at release) launches on the release cycle and re-enters MUL_WAIT.
- MulCnt never underflows or wraps.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined:
  - StallCount increments by 1 every cycle with Rst=1 and PCWrite=0.
  - It saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: StallCount is tied to 32'h0 and no counter logic is built.

Test Plan:
- Reset: hold Rst=0 for 2 cycles with BranchTaken=1 and ID_IsMul=1 -> all outputs at defaults, MulBusy=0, StallCount=0.
- Load-use: EX_R_Enable=1, EX_DstReg=8, ID_Rs=8 for 1 cycle, then EX_R_Enable=0 -> PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for exactly 1 cycle. Repeat with EX_DstReg=0 -> no stall.
- Mul, MUL_LATENCY=3: ID_IsMul=1 for 1 cycle -> MUL_WAIT for 2 cycles with MulBusy=1, EXMEM_Bubble=1, IDEX_Write=0, then defaults. StallCount=2 with STALL_COUNTER_EN.
- Simultaneous events: BranchTaken=1, LoadUse=1 and ID_IsMul=1 in one cycle -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, no MUL_WAIT entry.
- Reset mid-mul: Rst=0 on the 2nd MUL_WAIT cycle -> next cycle RUN, MulBusy=0. A subsequent mul then gets the full 2 stall cycles.
- Back-to-back mul: ID_IsMul=1 on the release cycle -> immediate re-entry to MUL_WAIT, giving 4 total stall cycles over the two muls.
